// File: rtl/bram_scan_pkg.sv
// Shared types and MISR helper for the BRAM read-back scanner.
package bram_scan_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} scan_state_e;

  localparam logic [63:0] MISR_SEED = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam int MISR_TAP_A = 63;
  localparam int MISR_TAP_B = 62;
  localparam int MISR_TAP_C = 60;
  localparam int MISR_TAP_D = 59;

  function automatic logic [63:0] misr_step(input logic [63:0] s, input logic [63:0] d);
    logic fb;
    fb = s[MISR_TAP_A] ^ s[MISR_TAP_B] ^ s[MISR_TAP_C] ^ s[MISR_TAP_D];
    return {s[62:0], fb} ^ d;
  endfunction

endpackage

// File: rtl/bram_scan_fifo.sv
// Small synchronous FIFO; push is accepted when full only if a pop happens in the same cycle.
module bram_scan_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wdata,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rdata,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (cnt_q != '0);
    do_push  = push && ((cnt_q != CW'(DEPTH)) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
    if (do_push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/bram_readback_scan.sv
// Sweeps an address window over a bank range and folds read data into a 64-bit MISR.
// Optional READBACK_STREAM_EN adds a credit-gated output stream; folding then happens on pop.
module bram_readback_scan
  import bram_scan_pkg::*;
#(
  parameter int DWIDTH       = 16,
  parameter int MAT_MUL_SIZE = 4,
  parameter int AWIDTH       = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [7:0]                       first_bank,
  input  logic [7:0]                       last_bank,
  input  logic [AWIDTH-1:0]                addr_start,
  input  logic [AWIDTH:0]                  addr_count,
  output logic                             busy,
  output logic                             done,
  output logic [63:0]                      signature,
  output logic [18:0]                      words_read,
  output logic [7:0]                       bram_select,
  output logic [AWIDTH-1:0]                bram_addr_ext,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0]   bram_wdata_ext,
  output logic [MAT_MUL_SIZE-1:0]          bram_we_ext,
`ifdef READBACK_STREAM_EN
  output logic                             rd_valid,
  input  logic                             rd_ready,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0]   rd_data,
  output logic [7:0]                       rd_bank,
  output logic [AWIDTH-1:0]                rd_addr,
`endif
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0]   bram_rdata_ext
);
  localparam int WW = MAT_MUL_SIZE*DWIDTH;
  localparam int RL = READ_LATENCY;

  scan_state_e       state_q, state_d;
  logic [7:0]        bank_q, bank_d, last_q, last_d;
  logic [AWIDTH-1:0] addr_q, addr_d, astart_q, astart_d;
  logic [AWIDTH:0]   rem_q, rem_d, count_q, count_d;
  logic [RL-1:0]     vld_pipe_q, vld_pipe_d;
  logic [63:0]       sig_q, sig_d;
  logic [18:0]       words_q, words_d;
  logic              issue, can_issue, pipe_idle, fold_en;
  logic [63:0]       fold_word;

`ifdef READBACK_STREAM_EN
  localparam int FD = RL + 1;
  localparam int FW = WW + 8 + AWIDTH;

  logic [7:0]              bank_pipe_q [RL];
  logic [AWIDTH-1:0]       addr_pipe_q [RL];
  logic [FW-1:0]           fifo_rdata;
  logic                    fifo_empty, fifo_pop;
  logic [$clog2(FD+1)-1:0] fifo_cnt;

  bram_scan_fifo #(.WIDTH(FW), .DEPTH(FD)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (vld_pipe_q[RL-1]),
    .wdata ({bank_pipe_q[RL-1], addr_pipe_q[RL-1], bram_rdata_ext}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign rd_valid  = !fifo_empty;
  assign fifo_pop  = rd_valid && rd_ready;
  assign rd_data   = fifo_rdata[WW-1:0];
  assign rd_addr   = fifo_rdata[WW +: AWIDTH];
  assign rd_bank   = fifo_rdata[FW-1 -: 8];
  assign fold_en   = fifo_pop;
  assign fold_word = 64'(rd_data);
  // Every in-flight read already owns a FIFO slot, so the FIFO can never overflow.
  assign can_issue = (FD - int'(fifo_cnt)) > $countones(vld_pipe_q);
  assign pipe_idle = (vld_pipe_q == '0) && fifo_empty;

  always_ff @(posedge clk) begin
    bank_pipe_q[0] <= bank_q;
    addr_pipe_q[0] <= addr_q;
    for (int i = 1; i < RL; i++) begin
      bank_pipe_q[i] <= bank_pipe_q[i-1];
      addr_pipe_q[i] <= addr_pipe_q[i-1];
    end
  end
`else
  assign fold_en   = vld_pipe_q[RL-1];
  assign fold_word = 64'(bram_rdata_ext);
  assign can_issue = 1'b1;
  assign pipe_idle = (vld_pipe_q == '0);
`endif

  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    last_d   = last_q;
    addr_d   = addr_q;
    astart_d = astart_q;
    rem_d    = rem_q;
    count_d  = count_q;
    sig_d    = sig_q;
    words_d  = words_q;
    issue    = 1'b0;
    if (fold_en) begin
      sig_d   = misr_step(sig_q, fold_word);
      words_d = words_q + 19'd1;
    end
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          last_d   = (last_bank < first_bank) ? first_bank : last_bank;
          astart_d = addr_start;
          count_d  = addr_count;
          bank_d   = first_bank;
          addr_d   = addr_start;
          rem_d    = addr_count;
          sig_d    = MISR_SEED;
          words_d  = '0;
          state_d  = (addr_count == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (can_issue) begin
          issue = 1'b1;
          if (rem_q == (AWIDTH+1)'(1)) begin
            if (bank_q == last_q) begin
              state_d = ST_DRAIN;
            end else begin
              bank_d = bank_q + 8'd1;
              addr_d = astart_q;
              rem_d  = count_q;
            end
          end else begin
            addr_d = addr_q + AWIDTH'(1);
            rem_d  = rem_q - (AWIDTH+1)'(1);
          end
        end
      end
      ST_DRAIN: if (pipe_idle) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
    vld_pipe_d    = vld_pipe_q << 1;
    vld_pipe_d[0] = issue;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bank_q     <= '0;
      last_q     <= '0;
      addr_q     <= '0;
      astart_q   <= '0;
      rem_q      <= '0;
      count_q    <= '0;
      vld_pipe_q <= '0;
      sig_q      <= '0;
      words_q    <= '0;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      astart_q   <= astart_d;
      rem_q      <= rem_d;
      count_q    <= count_d;
      vld_pipe_q <= vld_pipe_d;
      sig_q      <= sig_d;
      words_q    <= words_d;
    end
  end

  assign busy           = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign done           = (state_q == ST_DONE);
  assign signature      = sig_q;
  assign words_read     = words_q;
  assign bram_select    = bank_q;
  assign bram_addr_ext  = addr_q;
  assign bram_wdata_ext = '0;
  assign bram_we_ext    = '0;

endmodule
